avalon_st_sink: RTL

AVALON_ST_SINK -- requirements
Module: avalon_st_sink

---
 rtl/avalon_st_sink.sv | 118 +++++++++++
 1 files changed

// File: rtl/avalon_st_sink.sv
// Avalon-ST sink: show-ahead buffer with a registered-ready accept FSM.
// Define AVALON_ST_SINK_SEQ_CHECK_EN to build the sticky sequence-error checker.
module avalon_st_sink #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              en,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [15:0]       beat_count,
    output logic              seq_error
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {INIT, ACCEPT, FULL, HOLD} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_next;
    logic [15:0]       r_beat_count;
    logic              w_push;
    logic              w_pop;

    // in_ready decodes straight from the state register, so it never depends on this cycle's inputs.
    assign in_ready   = (r_state == ACCEPT);
    assign out_valid  = (r_count != '0);
    assign out_data   = r_mem[r_rd_ptr];
    assign beat_count = r_beat_count;
    assign w_push     = in_valid & in_ready;
    assign w_pop      = out_valid & out_ready;

    // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_ONE;
            2'b01:   w_count_next = r_count - CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        if (!en)
            w_state_next = HOLD;
        else if (w_count_next == CNT_FULL)
            w_state_next = FULL;
        else
            w_state_next = ACCEPT;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= INIT;
            r_count      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_beat_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            if (w_push) begin
                r_wr_ptr     <= r_wr_ptr + PTR_ONE;
                r_beat_count <= r_beat_count + 16'd1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage is deliberately left unreset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= in_data;
    end

`ifdef AVALON_ST_SINK_SEQ_CHECK_EN
    localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1);

    logic              r_seen;
    logic [DATA_W-1:0] r_expected;
    logic              r_seq_error;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_seen      <= 1'b0;
            r_expected  <= '0;
            r_seq_error <= 1'b0;
        end else if (w_push) begin
            r_seen     <= 1'b1;
            r_expected <= in_data + DATA_ONE;
            if (r_seen && (in_data != r_expected))
                r_seq_error <= 1'b1;
        end
    end

    assign seq_error = r_seq_error;
`else
    assign seq_error = 1'b0;
`endif

endmodule
